// File: rtl/clkm_start_ctrl.sv
// Start-up sequencer for the clock manager: drives its reset and start pulse,
// waits for done with a timeout, retries a bounded number of times.
module clkm_start_ctrl #(
    parameter int RST_CYC     = 2,
    parameter int SETTLE_CYC  = 4,
    parameter int START_CYC   = 2,
    parameter int TIMEOUT_CYC = 1024,
    parameter int MAX_RETRY   = 2,
    parameter int CNT_W       = 16
) (
    input  logic       clk_50_0,
    input  logic       reset_in,
    input  logic       restart,
    input  logic       done,
    output logic       cm_reset_n,
    output logic       cm_start_n,
    output logic       ready,
    output logic       fail,
    output logic [1:0] retry_cnt
);

    typedef enum logic [2:0] {
        ST_RST,
        ST_SETTLE,
        ST_START,
        ST_WAIT,
        ST_READY,
        ST_FAIL
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRY);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [1:0]       retry_q;
    logic             doneMeta_q;
    logic             doneSync_q;
    logic             cmResetN_q;
    logic             cmStartN_q;
    logic             ready_q;
    logic             fail_q;

    assign cnt_d = cnt_q + CNT_W'(1);

    // done comes from the manager's own clock domain
    always_ff @(posedge clk_50_0) begin
        if (!reset_in) begin
            doneMeta_q <= 1'b0;
            doneSync_q <= 1'b0;
        end else begin
            doneMeta_q <= done;
            doneSync_q <= doneMeta_q;
        end
    end

    always_ff @(posedge clk_50_0) begin
        if (!reset_in) begin
            state_q    <= ST_RST;
            cnt_q      <= '0;
            retry_q    <= 2'd0;
            cmResetN_q <= 1'b0;
            cmStartN_q <= 1'b1;
            ready_q    <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_q    <= ST_SETTLE;
                        cnt_q      <= '0;
                        cmResetN_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_q    <= ST_START;
                        cnt_q      <= '0;
                        cmStartN_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_START: begin
                    if (cnt_q == START_LAST) begin
                        state_q    <= ST_WAIT;
                        cnt_q      <= '0;
                        cmStartN_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_WAIT: begin
                    // done on the timeout cycle still counts as success
                    if (doneSync_q) begin
                        state_q <= ST_READY;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_q      <= '0;
                        cmResetN_q <= 1'b0;
                        if (retry_q < RETRY_MAX) begin
                            state_q <= ST_RST;
                            retry_q <= retry_q + 2'd1;
                        end else begin
                            state_q <= ST_FAIL;
                            fail_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_READY: begin
                    if (!doneSync_q || restart) begin
                        state_q    <= ST_RST;
                        cnt_q      <= '0;
                        retry_q    <= 2'd0;
                        cmResetN_q <= 1'b0;
                        ready_q    <= 1'b0;
                    end
                end
                ST_FAIL: begin
                    if (restart) begin
                        state_q <= ST_RST;
                        cnt_q   <= '0;
                        retry_q <= 2'd0;
                        fail_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_RST;
                    cnt_q      <= '0;
                    retry_q    <= 2'd0;
                    cmResetN_q <= 1'b0;
                    cmStartN_q <= 1'b1;
                    ready_q    <= 1'b0;
                    fail_q     <= 1'b0;
                end
            endcase
        end
    end

    assign cm_reset_n = cmResetN_q;
    assign cm_start_n = cmStartN_q;
    assign ready      = ready_q;
    assign fail       = fail_q;
    assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_clkm_start_ctrl.sv
// Bench for clkm_start_ctrl: directed sequence with random timing, checked every
// cycle against a timeline model plus directed waveform measurements.
module tb_clkm_start_ctrl;

    localparam int RST_CYC     = 2;
    localparam int SETTLE_CYC  = 4;
    localparam int START_CYC   = 2;
    localparam int TIMEOUT_CYC = 20;
    localparam int MAX_RETRY   = 2;
    localparam int WAIT_AT     = RST_CYC + SETTLE_CYC + START_CYC;
    localparam int ATTEMPT     = WAIT_AT + TIMEOUT_CYC;
    localparam int MAXC        = 1024;

    logic       clk = 1'b0;
    logic       resetIn;
    logic       restart;
    logic       done;
    logic       cmResetN;
    logic       cmStartN;
    logic       ready;
    logic       fail;
    logic [1:0] retryCnt;

    int compared   = 0;
    int mismatched = 0;
    int cycleNum   = 0;

    int mElapsed;
    int mRetry;
    bit mReady;
    bit mFail;
    bit syncQ[$];

    logic       trRstN   [MAXC];
    logic       trStartN [MAXC];
    logic       trReady  [MAXC];
    logic       trFail   [MAXC];
    logic [1:0] trRetry  [MAXC];

    clkm_start_ctrl #(
        .RST_CYC(RST_CYC), .SETTLE_CYC(SETTLE_CYC), .START_CYC(START_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY), .CNT_W(16)
    ) dut (
        .clk_50_0(clk), .reset_in(resetIn), .restart(restart), .done(done),
        .cm_reset_n(cmResetN), .cm_start_n(cmStartN), .ready(ready),
        .fail(fail), .retry_cnt(retryCnt)
    );

    always #10 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Model tracks elapsed cycles since the attempt began; phase follows from arithmetic
    function automatic void modelEdge();
        bit doneS;
        if (!resetIn) begin
            mElapsed = 0;
            mRetry   = 0;
            mReady   = 1'b0;
            mFail    = 1'b0;
            syncQ    = {1'b0, 1'b0};
        end else begin
            doneS = syncQ.pop_front();
            syncQ.push_back(done);
            if (mReady) begin
                if (!doneS || restart) begin
                    mReady = 1'b0; mRetry = 0; mElapsed = 0;
                end
            end else if (mFail) begin
                if (restart) begin
                    mFail = 1'b0; mRetry = 0; mElapsed = 0;
                end
            end else if (mElapsed >= WAIT_AT && doneS) begin
                mReady = 1'b1;
            end else if (mElapsed == ATTEMPT - 1) begin
                if (mRetry < MAX_RETRY) begin
                    mRetry++; mElapsed = 0;
                end else begin
                    mFail = 1'b1;
                end
            end else begin
                mElapsed++;
            end
        end
    endfunction

    task automatic checkCycle();
        bit running;
        bit expRstN;
        bit expStartN;
        running   = !mReady && !mFail;
        expRstN   = !(mFail || (running && mElapsed < RST_CYC));
        expStartN = !(running && mElapsed >= RST_CYC + SETTLE_CYC && mElapsed < WAIT_AT);
        checkOutput($sformatf("cyc%0d_outputs", cycleNum),
                    {26'b0, cmResetN, cmStartN, ready, fail, retryCnt},
                    {26'b0, expRstN, expStartN, mReady, mFail, 2'(mRetry)});
        checkOutput($sformatf("cyc%0d_ready_fail_excl", cycleNum), 32'(ready & fail), 32'(0));
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
        cycleNum++;
        trRstN[cycleNum]   = cmResetN;
        trStartN[cycleNum] = cmStartN;
        trReady[cycleNum]  = ready;
        trFail[cycleNum]   = fail;
        trRetry[cycleNum]  = retryCnt;
        checkCycle();
    endtask

    task automatic applyStimulus(input logic r, input logic rs, input logic d, input int n);
        resetIn = r;
        restart = rs;
        done    = d;
        repeat (n) tick();
    endtask

    function automatic logic trAt(input int sel, input int i);
        case (sel)
            0:       return trRstN[i];
            1:       return trStartN[i];
            2:       return trReady[i];
            default: return trFail[i];
        endcase
    endfunction

    function automatic int firstIdx(input int sel, input int from, input logic val);
        for (int i = from; i <= cycleNum; i++)
            if (trAt(sel, i) === val) return i;
        return -1;
    endfunction

    function automatic int runLen(input int sel, input int from);
        int   n = 0;
        logic v = trAt(sel, from);
        for (int i = from; i <= cycleNum; i++) begin
            if (trAt(sel, i) !== v) break;
            n++;
        end
        return n;
    endfunction

    function automatic int firstFall(input int from);
        for (int i = from + 1; i <= cycleNum; i++)
            if (trStartN[i-1] === 1'b1 && trStartN[i] === 1'b0) return i;
        return -1;
    endfunction

    initial begin
        int base, doneRise, dropAt, rdyFall, s1, s2, s3, rIdx, c, rel, n;
        resetIn = 1'b0; restart = 1'b0; done = 1'b0;
        mElapsed = 0; mRetry = 0; mReady = 1'b0; mFail = 1'b0;
        syncQ = {1'b0, 1'b0};

        applyStimulus(1'b0, 1'b0, 1'b0, 3);
        checkOutput("reset_cm_reset_n", 32'(cmResetN), 32'(0));
        checkOutput("reset_cm_start_n", 32'(cmStartN), 32'(1));
        checkOutput("reset_ready", 32'(ready), 32'(0));
        checkOutput("reset_fail", 32'(fail), 32'(0));
        checkOutput("reset_retry_cnt", 32'(retryCnt), 32'(0));
        base = cycleNum;

        // Normal bring-up, done arrives 5 cycles into WAIT
        applyStimulus(1'b1, 1'b0, 1'b0, WAIT_AT + 5);
        doneRise = cycleNum;
        applyStimulus(1'b1, 1'b0, 1'b1, 6);
        checkOutput("t1_rst_low_len", runLen(0, base), RST_CYC);
        checkOutput("t1_start_offset", firstIdx(1, base, 1'b0) - base, RST_CYC + SETTLE_CYC);
        checkOutput("t1_start_len", runLen(1, firstIdx(1, base, 1'b0)), START_CYC);
        checkOutput("t1_ready_latency", firstIdx(2, doneRise, 1'b1) - doneRise, 3);
        checkOutput("t1_retry_cnt", 32'(retryCnt), 32'(0));

        // Loss of lock, then done never returns: retries then FAIL
        dropAt = cycleNum;
        applyStimulus(1'b1, 1'b0, 1'b0, 4);
        for (int i = 0; i < 76; i++)
            applyStimulus(1'b1, 1'($urandom_range(7) == 0), 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 16);
        rdyFall = firstIdx(2, dropAt, 1'b0);
        checkOutput("t4_ready_drop_latency", rdyFall - dropAt, 3);
        checkOutput("t4_rst_low_len", runLen(0, rdyFall), RST_CYC);
        s1 = firstFall(rdyFall);
        s2 = firstFall(s1);
        s3 = firstFall(s2);
        checkOutput("t4_first_start", s1 - rdyFall, RST_CYC + SETTLE_CYC);
        checkOutput("t2_period_1_2", s2 - s1, ATTEMPT);
        checkOutput("t2_period_2_3", s3 - s2, ATTEMPT);
        checkOutput("t2_retry_at_s1", 32'(trRetry[s1]), 32'(0));
        checkOutput("t2_retry_at_s2", 32'(trRetry[s2]), 32'(1));
        checkOutput("t2_retry_at_s3", 32'(trRetry[s3]), 32'(2));
        checkOutput("t2_fail_time", firstIdx(3, s3, 1'b1) - s3, START_CYC + TIMEOUT_CYC);
        checkOutput("t2_fail", 32'(fail), 32'(1));
        checkOutput("t2_cm_reset_n", 32'(cmResetN), 32'(0));
        checkOutput("t2_ready", 32'(ready), 32'(0));
        checkOutput("t2_retry_sat", 32'(retryCnt), 32'(MAX_RETRY));

        // Restart out of FAIL with done already high
        applyStimulus(1'b1, 1'b0, 1'b1, 3);
        checkOutput("t3_fail_holds", 32'(fail), 32'(1));
        applyStimulus(1'b1, 1'b1, 1'b1, 1);
        rIdx = cycleNum;
        applyStimulus(1'b1, 1'b0, 1'b1, 14);
        checkOutput("t3_fail_cleared", 32'(trFail[rIdx]), 32'(0));
        checkOutput("t3_retry_cleared", 32'(trRetry[rIdx]), 32'(0));
        checkOutput("t3_rst_low_len", runLen(0, rIdx), RST_CYC);
        checkOutput("t3_ready_time", firstIdx(2, rIdx, 1'b1) - rIdx, WAIT_AT + 1);

        // done falling and restart seen on the same edge act once
        c = cycleNum;
        applyStimulus(1'b1, 1'b0, 1'b0, 2);
        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 4);
        checkOutput("both_ready_drop", firstIdx(2, c, 1'b0) - c, 3);
        checkOutput("both_rst_low_len", runLen(0, c + 3), RST_CYC);

        // Reset lands on the second start-low cycle of the second attempt
        applyStimulus(1'b1, 1'b0, 1'b0, 31);
        checkOutput("t5_pre_start_low", 32'(cmStartN), 32'(0));
        checkOutput("t5_pre_retry", 32'(retryCnt), 32'(1));
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        checkOutput("t5_cm_start_n", 32'(cmStartN), 32'(1));
        checkOutput("t5_cm_reset_n", 32'(cmResetN), 32'(0));
        checkOutput("t5_retry_cnt", 32'(retryCnt), 32'(0));
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        rel = cycleNum;

        // Stale done raised during SETTLE, restart during WAIT ignored
        n = int'($urandom_range(RST_CYC, RST_CYC + SETTLE_CYC - 1));
        applyStimulus(1'b1, 1'b0, 1'b0, n);
        applyStimulus(1'b1, 1'b0, 1'b1, WAIT_AT - n);
        applyStimulus(1'b1, 1'b1, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 1'b1, 4);
        checkOutput("t6_start_offset", firstIdx(1, rel, 1'b0) - rel, RST_CYC + SETTLE_CYC);
        checkOutput("t6_start_len", runLen(1, rel + RST_CYC + SETTLE_CYC), START_CYC);
        checkOutput("t6_ready_time", firstIdx(2, rel, 1'b1) - rel, WAIT_AT + 1);
        checkOutput("t6_ready_held", runLen(2, rel + WAIT_AT + 1), 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
